// File: rtl/turn_controller_if.sv
// Handshake bundle between the turn sequencer, the cronometer, the auto-mover and the board.
// The sequencer attaches through the slave modport; the board/test side attaches through master.
interface turn_controller_if #(
  parameter int TURN_W = 4
) ();
  logic              start;
  logic              moveValid;
  logic              timeout;
  logic              autoMoveAck;
  logic              gameOver;
  logic              timerRst;
  logic              autoMoveReq;
  logic              player;
  logic [TURN_W-1:0] turnCount;
  logic              done;
  logic              forfeit;

  modport slave (
    input  start, moveValid, timeout, autoMoveAck, gameOver,
    output timerRst, autoMoveReq, player, turnCount, done, forfeit
  );

  modport master (
    output start, moveValid, timeout, autoMoveAck, gameOver,
    input  timerRst, autoMoveReq, player, turnCount, done, forfeit
  );
endinterface

// File: rtl/turn_controller.sv
// Two-player turn sequencer: alternates sides, requests auto-moves on timeout, counts turns.
// Optional per-player strike-out forfeit is enabled by defining TURN_STRIKES_EN.
module turn_controller #(
  parameter int MAX_TURNS = 9,
  parameter int TURN_W    = 4
`ifdef TURN_STRIKES_EN
  , parameter int STRIKE_LIMIT = 2
`endif
) (
  input  logic clk,
  input  logic rst,
  turn_controller_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_AUTO, S_SWITCH, S_DONE} state_t;

  localparam logic [TURN_W-1:0] MAX_T = TURN_W'(MAX_TURNS);

  state_t            state_q, state_d;
  logic              player_q, player_d;
  logic [TURN_W-1:0] turn_count_q, turn_count_d;
  logic              timer_rst_q, timer_rst_d;
  logic              auto_req_q, auto_req_d;
  logic              done_q, done_d;
  logic [TURN_W-1:0] turn_inc;

`ifdef TURN_STRIKES_EN
  localparam int STRIKE_W = $clog2(STRIKE_LIMIT + 1);
  localparam logic [STRIKE_W-1:0] STRIKE_MAX = STRIKE_W'(STRIKE_LIMIT);
  logic [STRIKE_W-1:0] strike_q [0:1];
  logic [STRIKE_W-1:0] strike_d [0:1];
  logic [STRIKE_W-1:0] strike_inc;
  logic                forfeit_q, forfeit_d;
`endif

  assign turn_inc = turn_count_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    player_d     = player_q;
    turn_count_d = turn_count_q;
`ifdef TURN_STRIKES_EN
    strike_d   = strike_q;
    forfeit_d  = forfeit_q;
    strike_inc = strike_q[player_q] + 1'b1;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d      = S_PLAY;
          player_d     = 1'b0;
          turn_count_d = '0;
`ifdef TURN_STRIKES_EN
          strike_d[0] = '0;
          strike_d[1] = '0;
          forfeit_d   = 1'b0;
`endif
        end
      end
      S_PLAY: begin
        if (bus.gameOver) begin
          state_d = S_DONE;
        end else if (bus.moveValid) begin
          state_d = S_SWITCH;
`ifdef TURN_STRIKES_EN
          strike_d[player_q] = '0;
`endif
        end else if (bus.timeout) begin
`ifdef TURN_STRIKES_EN
          strike_d[player_q] = strike_inc;
          if (strike_inc == STRIKE_MAX) begin
            state_d   = S_DONE;
            forfeit_d = 1'b1;
          end else begin
            state_d = S_AUTO;
          end
`else
          state_d = S_AUTO;
`endif
        end
      end
      S_AUTO: begin
        if (bus.gameOver)         state_d = S_DONE;
        else if (bus.autoMoveAck) state_d = S_SWITCH;
      end
      S_SWITCH: begin
        player_d     = ~player_q;
        turn_count_d = turn_inc;
        state_d      = (turn_inc == MAX_T) ? S_DONE : S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they are Moore-aligned with state_q.
    timer_rst_d = (state_d == S_IDLE) || (state_d == S_SWITCH) || (state_d == S_DONE);
    auto_req_d  = (state_d == S_AUTO);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      player_q     <= 1'b0;
      turn_count_q <= '0;
      timer_rst_q  <= 1'b1;
      auto_req_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef TURN_STRIKES_EN
      strike_q[0]  <= '0;
      strike_q[1]  <= '0;
      forfeit_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      player_q     <= player_d;
      turn_count_q <= turn_count_d;
      timer_rst_q  <= timer_rst_d;
      auto_req_q   <= auto_req_d;
      done_q       <= done_d;
`ifdef TURN_STRIKES_EN
      strike_q[0]  <= strike_d[0];
      strike_q[1]  <= strike_d[1];
      forfeit_q    <= forfeit_d;
`endif
    end
  end

  assign bus.timerRst    = timer_rst_q;
  assign bus.autoMoveReq = auto_req_q;
  assign bus.player      = player_q;
  assign bus.turnCount   = turn_count_q;
  assign bus.done        = done_q;
`ifdef TURN_STRIKES_EN
  assign bus.forfeit     = forfeit_q;
`else
  assign bus.forfeit     = 1'b0;
`endif
endmodule

// File: tb/tb_turn_controller.sv
// Directed scenarios followed by random play, all checked against a game-level reference model.
module tb_turn_controller;
  localparam int MAX_TURNS = 9;
  localparam int TURN_W    = 4;
  localparam int STRIKES   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  turn_controller_if #(.TURN_W(TURN_W)) bus ();

  turn_controller #(.MAX_TURNS(MAX_TURNS), .TURN_W(TURN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: game-level flags rather than a state register.
  bit in_game;        // game running (playing, awaiting auto-move, or changing sides)
  bit awaiting_auto;  // auto-mover asked to move for the current side
  bit changing_side;  // one-cycle hand-over in progress
  bit finished;
  bit m_player;
  int m_turns;
  bit m_forfeit;
  int strikes [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input bit st, input bit mv, input bit to, input bit ack, input bit go, input bit rs);
    if (rs) begin
      in_game = 0; awaiting_auto = 0; changing_side = 0; finished = 0;
      m_player = 0; m_turns = 0; m_forfeit = 0; strikes[0] = 0; strikes[1] = 0;
    end else if (changing_side) begin
      changing_side = 0;
      m_player = !m_player;
      m_turns++;
      if (m_turns == MAX_TURNS) begin
        in_game = 0; finished = 1;
      end
    end else if (in_game) begin
      if (go) begin
        in_game = 0; awaiting_auto = 0; finished = 1;
      end else if (awaiting_auto) begin
        if (ack) begin
          awaiting_auto = 0; changing_side = 1;
        end
      end else if (mv) begin
        changing_side = 1;
        strikes[m_player] = 0;
      end else if (to) begin
`ifdef TURN_STRIKES_EN
        strikes[m_player]++;
        if (strikes[m_player] == STRIKES) begin
          in_game = 0; finished = 1; m_forfeit = 1;
        end else begin
          awaiting_auto = 1;
        end
`else
        awaiting_auto = 1;
`endif
      end
    end else if (st) begin
      in_game = 1; finished = 0; m_player = 0; m_turns = 0; m_forfeit = 0;
      strikes[0] = 0; strikes[1] = 0;
    end
  endtask

  // One clock of stimulus, then every output compared with the model.
  task automatic step(input bit st, input bit mv, input bit to, input bit ack, input bit go, input bit rs);
    bus.start = st; bus.moveValid = mv; bus.timeout = to;
    bus.autoMoveAck = ack; bus.gameOver = go; rst = rs;
    @(posedge clk);
    model_edge(st, mv, to, ack, go, rs);
    #1;
    cyc++;
    $display("cyc %0d in st=%b mv=%b to=%b ack=%b go=%b rst=%b -> trst=%b req=%b pl=%b turns=%0d done=%b forf=%b",
             cyc, st, mv, to, ack, go, rs, bus.timerRst, bus.autoMoveReq, bus.player,
             bus.turnCount, bus.done, bus.forfeit);
    check_eq("timerRst",    32'(bus.timerRst),    32'(!in_game || changing_side));
    check_eq("autoMoveReq", 32'(bus.autoMoveReq), 32'(awaiting_auto));
    check_eq("player",      32'(bus.player),      32'(m_player));
    check_eq("turnCount",   32'(bus.turnCount),   32'(m_turns));
    check_eq("done",        32'(bus.done),        32'(finished));
    check_eq("forfeit",     32'(bus.forfeit),     32'(m_forfeit));
  endtask

  task automatic idle(input int n, input bit to);
    for (int i = 0; i < n; i++) step(0, 0, to, 0, 0, 0);
  endtask

  initial begin
    bus.start = 0; bus.moveValid = 0; bus.timeout = 0; bus.autoMoveAck = 0; bus.gameOver = 0;

    // Reset state
    step(0, 0, 0, 0, 0, 1);
    check_eq("rst_timerRst", 32'(bus.timerRst), 32'd1);
    check_eq("rst_turns", 32'(bus.turnCount), 32'd0);

    // Start, move five cycles later: one SWITCH cycle then B to move
    step(1, 0, 0, 0, 0, 0);
    check_eq("play_timerRst", 32'(bus.timerRst), 32'd0);
    idle(4, 0);
    step(0, 1, 0, 0, 0, 0);
    check_eq("switch_timerRst", 32'(bus.timerRst), 32'd1);
    idle(1, 0);
    check_eq("after_move_player", 32'(bus.player), 32'd1);
    check_eq("after_move_turns", 32'(bus.turnCount), 32'd1);

    // Timeout with late ack: request held throughout
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0, 0, 0);
      check_eq("auto_hold", 32'(bus.autoMoveReq), 32'd1);
    end
    step(0, 0, 1, 1, 0, 0);
    check_eq("ack_req_drop", 32'(bus.autoMoveReq), 32'd0);
    idle(1, 0);
    check_eq("after_auto_player", 32'(bus.player), 32'd0);
    check_eq("after_auto_turns", 32'(bus.turnCount), 32'd2);

    // Move and timeout together: move wins
    step(0, 1, 1, 0, 0, 0);
    check_eq("mv_to_req", 32'(bus.autoMoveReq), 32'd0);
    idle(1, 0);

    // Play out to the turn limit
    while (!bus.done && cyc < 200) begin
      step(0, 1, 0, 0, 0, 0);
      idle(1, 0);
    end
    check_eq("limit_done", 32'(bus.done), 32'd1);
    check_eq("limit_turns", 32'(bus.turnCount), 32'(MAX_TURNS));
    step(0, 1, 0, 0, 0, 0);
    check_eq("limit_hold", 32'(bus.turnCount), 32'(MAX_TURNS));
    step(1, 0, 0, 0, 0, 0);
    check_eq("restart_turns", 32'(bus.turnCount), 32'd0);
    check_eq("restart_player", 32'(bus.player), 32'd0);

    // gameOver beats timeout; reset mid-AUTO
    step(0, 0, 1, 0, 1, 0);
    check_eq("go_done", 32'(bus.done), 32'd1);
    check_eq("go_req", 32'(bus.autoMoveReq), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    check_eq("rst_auto_req", 32'(bus.autoMoveReq), 32'd0);
    check_eq("rst_auto_trst", 32'(bus.timerRst), 32'd1);

`ifdef TURN_STRIKES_EN
    // A times out, ack, B moves, A times out again: A forfeits
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(1, 0);
    step(0, 1, 0, 0, 0, 0);
    idle(1, 0);
    step(0, 0, 1, 0, 0, 0);
    check_eq("strike_done", 32'(bus.done), 32'd1);
    check_eq("strike_forfeit", 32'(bus.forfeit), 32'd1);
    check_eq("strike_player", 32'(bus.player), 32'd0);
`endif

    // Random play against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
